// File: rtl/contador_control.sv
// contador_control: user-controllable 6-bit up/down modulo counter feeding the dual seven-segment display.
//   Optional button debouncing is compiled in with the macro CONTADOR_DEBOUNCE_EN.
//   Ports:
//     clk      - system clock, rising edge
//     clr      - asynchronous active-low reset
//     btn_run  - raw run/pause pushbutton (toggles RUN/PAUSE on press)
//     btn_zero - raw count-clear pushbutton
//     sw_down  - direction switch, 0 = up, 1 = down
//     q        - current count, 0..MAX_COUNT
//     running  - high while in RUN
//     tick     - one-cycle pulse on every count update
//     wrap     - one-cycle pulse when a count update wraps
module contador_control #(
    parameter int CLK_DIV    = 50_000_000,
    parameter int DEB_CYCLES = 1_000_000,
    parameter int MAX_COUNT  = 63
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn_run,
    input  logic       btn_zero,
    input  logic       sw_down,
    output logic [5:0] q,
    output logic       running,
    output logic       tick,
    output logic       wrap
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [5:0] MAXQ = 6'(MAX_COUNT);

    typedef enum logic {PAUSE = 1'b0, RUN = 1'b1} state_t;
    state_t state, state_n;

    logic [1:0] run_sync, zero_sync, down_sync;
    logic run_lvl, zero_lvl, run_prev, zero_prev, run_evt, zero_evt;
    logic [PW-1:0] pre;
    logic [5:0] q_n;
    logic term, wrap_n;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            run_sync  <= '0;
            zero_sync <= '0;
            down_sync <= '0;
        end else begin
            run_sync  <= {run_sync[0], btn_run};
            zero_sync <= {zero_sync[0], btn_zero};
            down_sync <= {down_sync[0], sw_down};
        end
    end

`ifdef CONTADOR_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    logic [DW-1:0] run_cnt, zero_cnt;

    // A level is accepted only after DEB_CYCLES consecutive samples that differ from the current one.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            run_lvl  <= 1'b0;
            zero_lvl <= 1'b0;
            run_cnt  <= '0;
            zero_cnt <= '0;
        end else begin
            if (run_sync[1] == run_lvl) begin
                run_cnt <= '0;
            end else if (run_cnt == DEB_LAST) begin
                run_lvl <= run_sync[1];
                run_cnt <= '0;
            end else begin
                run_cnt <= run_cnt + DW'(1);
            end
            if (zero_sync[1] == zero_lvl) begin
                zero_cnt <= '0;
            end else if (zero_cnt == DEB_LAST) begin
                zero_lvl <= zero_sync[1];
                zero_cnt <= '0;
            end else begin
                zero_cnt <= zero_cnt + DW'(1);
            end
        end
    end
`else
    assign run_lvl  = run_sync[1];
    assign zero_lvl = zero_sync[1];
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            run_prev  <= 1'b0;
            zero_prev <= 1'b0;
        end else begin
            run_prev  <= run_lvl;
            zero_prev <= zero_lvl;
        end
    end

    assign run_evt  = run_lvl & ~run_prev;
    assign zero_evt = zero_lvl & ~zero_prev;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= PAUSE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (run_evt) state_n = (state == RUN) ? PAUSE : RUN;
    end

    assign running = (state == RUN);

    // The terminal prescaler edge is judged on the current state, so a pause landing on it still ticks.
    assign term = (state == RUN) && (pre == PRE_LAST);

    always_comb begin
        wrap_n = down_sync[1] ? (q == 6'd0) : (q == MAXQ);
        q_n    = down_sync[1] ? ((q == 6'd0) ? MAXQ : q - 6'd1)
                              : ((q == MAXQ) ? 6'd0 : q + 6'd1);
    end

    // Clear has priority over a coinciding tick; the prescaler only advances in RUN.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pre  <= '0;
            q    <= '0;
            tick <= 1'b0;
            wrap <= 1'b0;
        end else if (zero_evt) begin
            pre  <= '0;
            q    <= '0;
            tick <= 1'b0;
            wrap <= 1'b0;
        end else begin
            tick <= term;
            wrap <= term & wrap_n;
            if (term) q <= q_n;
            if (state == RUN) pre <= term ? '0 : pre + PW'(1);
        end
    end
endmodule

// File: tb/tb_contador_control.sv
// tb_contador_control: randomized bench for contador_control against a cycle-level behavioural model.
module tb_contador_control;
    localparam int CLK_DIV = 4;
    localparam int DEB     = 3;
    localparam int MAXC    = 9;
`ifdef CONTADOR_DEBOUNCE_EN
    localparam int DEPTH = DEB;
`else
    localparam int DEPTH = 0;
`endif

    logic clk = 1'b0, clr = 1'b1, btn_run = 1'b0, btn_zero = 1'b0, sw_down = 1'b0;
    logic [5:0] q;
    logic running, tick, wrap;
    int errors = 0, checks = 0;

    contador_control #(.CLK_DIV(CLK_DIV), .DEB_CYCLES(DEB), .MAX_COUNT(MAXC)) dut (
        .clk(clk), .clr(clr), .btn_run(btn_run), .btn_zero(btn_zero), .sw_down(sw_down),
        .q(q), .running(running), .tick(tick), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    int mq = 0, mpre = 0;
    bit mrun = 0, mtick = 0, mwrap = 0;
    bit [1:0] ms_run = 0, ms_zero = 0, ms_down = 0;
    bit [31:0] mh_run = 0, mh_zero = 0;
    bit mf_run = 0, mf_zero = 0, mp_run = 0, mp_zero = 0;

    // Accepted level flips once the last DEPTH synchronised samples all disagree with it.
    function automatic bit settle(input bit [31:0] h, input bit lvl, input bit now);
        bit [31:0] m;
        m = (32'd1 << DEPTH) - 32'd1;
        if (DEPTH == 0) return now;
        return (((h ^ {32{lvl}}) & m) == m) ? ~lvl : lvl;
    endfunction

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            mq = 0; mpre = 0; mrun = 0; mtick = 0; mwrap = 0;
            ms_run = 0; ms_zero = 0; ms_down = 0; mh_run = 0; mh_zero = 0;
            mf_run = 0; mf_zero = 0; mp_run = 0; mp_zero = 0;
        end else begin
            bit rev, zev, dn;
            rev = mf_run & ~mp_run;
            zev = mf_zero & ~mp_zero;
            dn  = ms_down[1];
            mh_run  = {mh_run[30:0], ms_run[1]};
            mh_zero = {mh_zero[30:0], ms_zero[1]};
            ms_run  = {ms_run[0], btn_run};
            ms_zero = {ms_zero[0], btn_zero};
            ms_down = {ms_down[0], sw_down};
            mp_run  = mf_run;
            mp_zero = mf_zero;
            mf_run  = settle(mh_run, mf_run, ms_run[1]);
            mf_zero = settle(mh_zero, mf_zero, ms_zero[1]);
            if (zev) begin
                mq = 0; mpre = 0; mtick = 0; mwrap = 0;
            end else begin
                mtick = mrun && (mpre == CLK_DIV - 1);
                mwrap = 0;
                if (mtick) begin
                    mwrap = dn ? (mq == 0) : (mq == MAXC);
                    mq = dn ? (mq + MAXC) % (MAXC + 1) : (mq + 1) % (MAXC + 1);
                end
                if (mrun) mpre = (mpre + 1) % CLK_DIV;
            end
            if (rev) mrun = ~mrun;
        end
    end

    always @(negedge clk) begin
        check("q", int'(q), mq);
        check("running", int'(running), int'(mrun));
        check("tick", int'(tick), int'(mtick));
        check("wrap", int'(wrap), int'(mwrap));
        check("q_le_max", int'(q <= 6'(MAXC)), 1);
    end

    task automatic zero_outputs(input string tag);
        check({tag, "_q"}, int'(q), 0);
        check({tag, "_running"}, int'(running), 0);
        check({tag, "_tick"}, int'(tick), 0);
        check({tag, "_wrap"}, int'(wrap), 0);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        bit was;
        #2 clr = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            {btn_run, btn_zero, sw_down} = 3'($urandom);
        end
        zero_outputs("reset");
        @(posedge clk); #1;
        clr = 1'b1; btn_run = 0; btn_zero = 0; sw_down = 0;
        cycles(10);
        zero_outputs("idle");

        lat = 0;
        btn_run = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (n == 10) btn_run = 1'b0;
            if (running && lat == 0) lat = n;
        end
        check("run_latency", lat, 3 + DEPTH);
        cycles(50);

        sw_down = 1'b1;
        cycles(30);
        sw_down = 1'b0;
        cycles(30);

        was = running;
        btn_run = 1'b1;
        cycles(2);
        btn_run = 1'b0;
        cycles(15);
        check("glitch", int'(running), DEPTH > 2 ? int'(was) : int'(!was));

        @(posedge clk); #1;
        clr = 1'b0;
        cycles(1);
        clr = 1'b1;
        btn_run = 1'b1;
        cycles(3);
        #2 clr = 1'b0;
        #1 zero_outputs("mid_deb_clr");
        btn_run = 1'b0;
        cycles(1);
        clr = 1'b1;
        cycles(15);
        check("press_discarded", int'(running), 0);

        for (int i = 0; i < 200; i++) begin
            int act;
            act = $urandom_range(0, 19);
            if (act < 8) begin
                btn_run = 1'b1;
                cycles($urandom_range(1, 8));
                btn_run = 1'b0;
            end else if (act < 12) begin
                btn_zero = 1'b1;
                cycles($urandom_range(1, 8));
                btn_zero = 1'b0;
            end else if (act < 16) begin
                sw_down = ~sw_down;
            end else if (act == 19) begin
                @(posedge clk);
                #3 clr = 1'b0;
                #1 zero_outputs("async_clr");
                @(posedge clk); #1;
                clr = 1'b1;
            end
            cycles($urandom_range(0, 30));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
